// File: rtl/instr_sequencer.sv
// Program store + PC front end for the 8-bit cpu; executes NOP/JMP/JZ/JS/HALT locally and forwards ALU-class words.
// Each instruction is FETCH then EXEC (2 cycles); a forwarded word is registered for one cycle; no backpressure.
module instr_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic               zf,
    input  logic               sf,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JS   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [INSTR_W-1:0]   out_q, out_d;
    logic                 fresh_q, fresh_d;
    logic                 zf_q, zf_d;
    logic                 sf_q, sf_d;

    logic [INSTR_W-1:0]   mem [DEPTH];

    logic [3:0]           opcode;
    logic [ADDR_W-1:0]    target;
    logic [ADDR_W-1:0]    pc_inc;
    logic                 z_eff;
    logic                 s_eff;
    logic                 prog_en;

    assign opcode  = ir_q[INSTR_W-1 -: 4];
    assign target  = ir_q[ADDR_W-1:0];
    assign pc_inc  = pc_q + ADDR_W'(1);
    // Live flags belong to the op issued two edges ago; otherwise fall back to the snapshot.
    assign z_eff   = fresh_q ? zf : zf_q;
    assign s_eff   = fresh_q ? sf : sf_q;
    assign prog_en = (state_q == S_IDLE) || (state_q == S_HALT);

    always_ff @(posedge clk) begin
        if (prog_we && prog_en) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        out_d   = '0;
        fresh_d = fresh_q;
        zf_d    = zf_q;
        sf_d    = sf_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                ir_d    = mem[pc_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (fresh_q) begin
                    zf_d = zf;
                    sf_d = sf;
                end
                state_d = S_FETCH;
                case (opcode)
                    OP_NOP: begin
                        pc_d    = pc_inc;
                        fresh_d = 1'b0;
                    end
                    OP_JMP: begin
                        pc_d    = target;
                        fresh_d = 1'b0;
                    end
                    OP_JZ: begin
                        pc_d    = z_eff ? target : pc_inc;
                        fresh_d = 1'b0;
                    end
                    OP_JS: begin
                        pc_d    = s_eff ? target : pc_inc;
                        fresh_d = 1'b0;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        out_d   = ir_q;
                        pc_d    = pc_inc;
                        fresh_d = 1'b1;
                    end
                endcase
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            out_q   <= '0;
            fresh_q <= 1'b0;
            zf_q    <= 1'b0;
            sf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            out_q   <= out_d;
            fresh_q <= fresh_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
        end
    end

    assign instr_out = out_q;
    assign pc        = pc_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: instruction-level reference model compared every cycle, plus literal checkpoints.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [19:0] prog_data = '0;
    logic        start = 1'b0;
    logic        zf = 1'b0;
    logic        sf = 1'b0;
    logic [19:0] instr_out;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;

    int checks = 0;
    int errors = 0;

    instr_sequencer #(.ADDR_W(8), .INSTR_W(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .zf        (zf),
        .sf        (sf),
        .instr_out (instr_out),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Reference model: program shadow plus an interpreter that spends one
    // cycle fetching and one cycle retiring each instruction.
    int mprog [256];
    bit m_run = 0, m_halt = 0, m_exec_next = 0, m_fresh = 0, m_zs = 0, m_ss = 0;
    int m_pc = 0, m_out = 0, m_ir = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_halt = 0; m_exec_next = 0; m_fresh = 0;
            m_zs = 0; m_ss = 0; m_pc = 0; m_out = 0; m_ir = 0;
        end else if (!m_run) begin
            if (prog_we) mprog[prog_addr] = prog_data;
            m_out = 0;
            if (start) begin
                m_run = 1; m_halt = 0; m_pc = 0; m_exec_next = 0;
            end
        end else if (!m_exec_next) begin
            m_ir = mprog[m_pc];
            m_out = 0;
            m_exec_next = 1;
        end else begin
            int op, t;
            bit z, s;
            op = (m_ir >> 16) & 15;
            t  = m_ir & 255;
            z  = m_fresh ? zf : m_zs;
            s  = m_fresh ? sf : m_ss;
            if (m_fresh) begin m_zs = zf; m_ss = sf; end
            m_out = 0;
            m_exec_next = 0;
            if (op == 15) begin
                m_run = 0; m_halt = 1;
            end else if (op == 0) begin
                m_pc = (m_pc + 1) % 256; m_fresh = 0;
            end else if (op == 9) begin
                m_pc = t; m_fresh = 0;
            end else if (op == 10) begin
                m_pc = z ? t : (m_pc + 1) % 256; m_fresh = 0;
            end else if (op == 14) begin
                m_pc = s ? t : (m_pc + 1) % 256; m_fresh = 0;
            end else begin
                m_out = m_ir; m_pc = (m_pc + 1) % 256; m_fresh = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (pc !== m_pc[7:0] || instr_out !== m_out[19:0] || busy !== m_run || halted !== m_halt) begin
                errors++;
                $display("FAIL model t=%0t pc %0d exp %0d out %h exp %h busy %b exp %b halted %b exp %b",
                         $time, pc, m_pc[7:0], instr_out, m_out[19:0], busy, m_run, halted, m_halt);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [19:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mprog[i] = 0;
        step();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_out", 32'(instr_out), 32'h0);
        chk("rst_busy_halted", {30'd0, busy, halted}, 32'h0);
        rst = 1'b0;

        // 1: single ALU op then HALT
        wr(8'd0, 20'h10105);
        wr(8'd1, 20'hF0000);
        kick();
        step();
        chk("t1_fetch_out", 32'(instr_out), 32'h0);
        step();
        chk("t1_issue_out", 32'(instr_out), 32'h10105);
        chk("t1_issue_pc", 32'(pc), 32'h1);
        step();
        chk("t1_one_cycle", 32'(instr_out), 32'h0);
        step();
        chk("t1_halted", {30'd0, busy, halted}, 32'h1);
        chk("t1_halt_pc", 32'(pc), 32'h1);

        // 2: JZ on live zero flag, taken and not taken
        wr(8'd1, 20'hA0005);
        wr(8'd5, 20'hF0000);
        wr(8'd2, 20'hF0000);
        zf = 1'b1;
        kick();
        repeat (4) step();
        chk("t2_jz_taken", 32'(pc), 32'h5);
        repeat (2) step();
        chk("t2_halt5", {24'd0, pc}, 32'h5);
        zf = 1'b0;
        kick();
        repeat (4) step();
        chk("t2_jz_fall", 32'(pc), 32'h2);
        repeat (2) step();
        chk("t2_halt2", {31'd0, halted}, 32'h1);

        // 4: JZ after NOP uses the snapshot taken from the ALU result
        wr(8'd1, 20'h00000);
        wr(8'd2, 20'hA0007);
        wr(8'd3, 20'hF0000);
        wr(8'd7, 20'hF0000);
        zf = 1'b1;
        kick();
        repeat (4) step();
        zf = 1'b0;
        repeat (2) step();
        chk("t4_jz_snapshot", 32'(pc), 32'h7);
        repeat (2) step();
        chk("t4_halt7", {31'd0, halted}, 32'h1);

        // JS via snapshot, taken then not taken
        wr(8'd2, 20'hE0009);
        wr(8'd9, 20'hF0000);
        sf = 1'b1;
        kick();
        repeat (4) step();
        sf = 1'b0;
        repeat (2) step();
        chk("t4_js_taken", 32'(pc), 32'h9);
        repeat (2) step();
        kick();
        repeat (6) step();
        chk("t4_js_fall", 32'(pc), 32'h3);
        repeat (2) step();
        chk("t4_halt3", {31'd0, halted}, 32'h1);

        // 5: write and start while busy are ignored
        wr(8'd2, 20'h00000);
        kick();
        prog_we = 1'b1; prog_addr = 8'd3; prog_data = 20'h12345;
        repeat (2) step();
        prog_we = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_start_busy", 32'(pc), 32'h2);
        repeat (4) step();
        chk("t5_we_busy_halt", {31'd0, halted}, 32'h1);
        chk("t5_we_busy_pc", 32'(pc), 32'h3);

        // 3: JMP 255 / NOP wrap loop, ended by an async reset mid-EXEC
        wr(8'd0, 20'h900FF);
        wr(8'd255, 20'h00000);
        kick();
        repeat (2) step();
        chk("t3_jmp255", 32'(pc), 32'hFF);
        repeat (2) step();
        chk("t3_wrap0", 32'(pc), 32'h0);
        repeat (2) step();
        chk("t3_again255", 32'(pc), 32'hFF);
        step();
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_pc", 32'(pc), 32'h0);
        chk("t6_rst_busy", {31'd0, busy}, 32'h0);
        step();
        rst = 1'b0;
        kick();
        repeat (2) step();
        chk("t6_replay_loop", 32'(pc), 32'hFF);
        #2 rst = 1'b1;
        step();
        rst = 1'b0;

        // 6: reset while an issued word is on the output
        wr(8'd0, 20'h10105);
        kick();
        repeat (2) step();
        chk("t6_pre_out", 32'(instr_out), 32'h10105);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_out", 32'(instr_out), 32'h0);
        chk("t6_rst_pc2", 32'(pc), 32'h0);
        step();
        rst = 1'b0;
        kick();
        repeat (2) step();
        chk("t6_replay_out", 32'(instr_out), 32'h10105);
        repeat (6) step();
        chk("t6_replay_halt", {24'd0, pc}, 32'h3);
        chk("t6_replay_halted", {31'd0, halted}, 32'h1);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
